// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks.
//   tx_state_t  - transmit FSM states
//   tx_cfg_t    - per-frame configuration captured with each accepted word
//   UART_DATA_W - data bits per frame
//   BAUD_SEL_*  - baud_sel encodings shared with the baud rate generator
package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [1:0] BAUD_SEL_19200  = 2'b00;
  localparam logic [1:0] BAUD_SEL_38400  = 2'b01;
  localparam logic [1:0] BAUD_SEL_57600  = 2'b10;
  localparam logic [1:0] BAUD_SEL_115200 = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic stop2;
  } tx_cfg_t;

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: word handshake into the UART transmitter.
//   tx_data/tx_valid/tx_ready - valid/ready word transfer
//   parity_en/parity_odd/stop2 - frame config, qualified by tx_valid
//   master: word producer, slave: uart_tx
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              parity_en;
  logic              parity_odd;
  logic              stop2;

  modport master (output tx_data, tx_valid, parity_en, parity_odd, stop2,
                  input  tx_ready);
  modport slave  (input  tx_data, tx_valid, parity_en, parity_odd, stop2,
                  output tx_ready);
endinterface

// File: rtl/uart_tx_baud_edge_det.sv
// baud_edge_det: turns the baud generator's clkout level into a
// single-clkin-cycle tick on each rising edge.
//   clkin     - system clock
//   rst_n     - async active-low reset
//   baud_clk  - baud clock level, synchronous to clkin
//   baud_tick - one-cycle pulse on each baud_clk rising edge
module baud_edge_det (
  input  logic clkin,
  input  logic rst_n,
  input  logic baud_clk,
  output logic baud_tick
);

  logic baud_clk_q;

  // Reset to 1 so a baud_clk already high at reset release is not
  // mistaken for a fresh rising edge.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) baud_clk_q <= 1'b1;
    else        baud_clk_q <= baud_clk;
  end

  assign baud_tick = baud_clk & ~baud_clk_q;

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, LSB first, optional parity, 1 or 2 stop bits.
// A one-entry holding register lets the next word be queued while a frame
// is on the line, so consecutive frames run with no idle gap.
//   clkin    - system clock (also clocks the baud generator)
//   rst_n    - async active-low reset
//   baud_clk - baud generator clkout level; each rising edge = one bit period
//   bus      - word handshake plus per-word frame config (slave side)
//   tx       - registered serial output, idles high
//   tx_busy  - frame in progress or a word waiting in the holding register
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
) (
  input  logic        clkin,
  input  logic        rst_n,
  input  logic        baud_clk,
  uart_tx_if.slave    bus,
  output logic        tx,
  output logic        tx_busy
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic              baud_tick;
  tx_state_t         state, state_d;
  logic              tx_d;

  logic [DATA_W-1:0] hold_data;
  tx_cfg_t           hold_cfg;
  logic              hold_full;

  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] cur_data;   // untouched copy for parity
  tx_cfg_t           cfg;
  logic [CNT_W-1:0]  bit_cnt;

  logic accept, load, shift_en, cnt_clr, cnt_inc, frame_end, par_bit;

  baud_edge_det u_edge (
    .clkin     (clkin),
    .rst_n     (rst_n),
    .baud_clk  (baud_clk),
    .baud_tick (baud_tick)
  );

  assign bus.tx_ready = ~hold_full;
  assign accept       = bus.tx_valid & ~hold_full;
  assign tx_busy      = (state != IDLE) | hold_full;
  assign par_bit      = (^cur_data) ^ cfg.parity_odd;

  // Next state / line value. Nothing moves without a baud tick; a load
  // only happens with hold_full set, so it never collides with accept.
  always_comb begin
    state_d   = state;
    tx_d      = tx;
    load      = 1'b0;
    shift_en  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    frame_end = 1'b0;
    if (baud_tick) begin
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            load    = 1'b1;
            tx_d    = 1'b0;
            state_d = START;
          end
        end
        START: begin
          tx_d    = shift[0];
          cnt_clr = 1'b1;
          state_d = DATA;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            if (cfg.parity_en) begin
              tx_d    = par_bit;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP1;
            end
          end else begin
            tx_d     = shift[1];
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
          end
        end
        PARITY: begin
          tx_d    = 1'b1;
          state_d = STOP1;
        end
        STOP1: begin
          if (cfg.stop2) begin
            tx_d    = 1'b1;
            state_d = STOP2;
          end else begin
            frame_end = 1'b1;
          end
        end
        STOP2:   frame_end = 1'b1;
        default: state_d = IDLE;
      endcase

      // Chain straight into the held word for a gapless stream.
      if (frame_end) begin
        if (hold_full) begin
          load    = 1'b1;
          tx_d    = 1'b0;
          state_d = START;
        end else begin
          tx_d    = 1'b1;
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      tx    <= tx_d;
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
      hold_cfg  <= '0;
      shift     <= '0;
      cur_data  <= '0;
      cfg       <= '0;
      bit_cnt   <= '0;
    end else begin
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= bus.tx_data;
        hold_cfg  <= '{parity_en: bus.parity_en, parity_odd: bus.parity_odd,
                       stop2: bus.stop2};
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shift    <= hold_data;
        cur_data <= hold_data;
        cfg      <= hold_cfg;
      end else if (shift_en) begin
        shift <= shift >> 1;
      end

      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmit stage. It sits directly downstream of the baud rate generator and consumes that generator's clkout as its bit-rate reference.
- It runs entirely on clkin (25 MHz). It detects rising edges of the baud clock level to get single-cycle bit ticks.
- It serialises 8-bit words with a valid/ready handshake. It supports optional parity and 1 or 2 stop bits, LSB first.
- A one-entry holding register allows back-to-back frames with no idle gap.

Parameters:
- DATA_W, 8, data bits per frame (fixed LSB-first ordering).

Ports:
- clkin  input  1  system clock, the same 25 MHz clock that feeds the baud generator.
- rst_n  input  1  reset, asynchronous, active-low.
- baud_clk  input  1  baud generator clkout level. It is synchronous to clkin; each rising edge marks one bit period.
- tx_data  input  DATA_W  word to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty; a word is accepted when tx_valid && tx_ready at a clkin edge.
- parity_en  input  1  append a parity bit. Sampled with tx_data at accept.
- parity_odd  input  1  1 = odd parity, 0 = even. Sampled at accept.
- stop2  input  1  1 = two stop bits, 0 = one. Sampled at accept.
- tx  output  1  serial line, registered; idle level is 1.
- tx_busy  output  1  high when a frame is in progress or the holding register is full.

Behaviour:
- Reset (rst_n low, async):
  - tx=1, tx_ready=1, tx_busy=0, state=IDLE, hold_full=0.
  - baud_clk_q=1, so a high baud_clk at reset release gives no spurious tick.
- Tick generation: baud_tick = baud_clk & ~baud_clk_q, where baud_clk_q is baud_clk registered. The tick is one clkin cycle wide.
- Handshake:
  - tx_ready = ~hold_full.
  - On accept, store {tx_data, parity_en, parity_odd, stop2} in the holding register and set hold_full.
  - Accept never changes the current frame.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2. All transitions occur only on baud_tick.
- IDLE: tx=1. On tick with hold_full:
  - load the shifter and config from hold, clear hold_full;
  - tx<=0, go to START.
- START: on tick, tx<=shift[0], bit counter=0, go to DATA.
- DATA: on tick, shift right and increment the counter.
  - After bit DATA_W-1 has been driven for one period: go to PARITY if parity_en (tx<=parity), else to STOP1 (tx<=1).
- Parity value: ^data for even parity; ~^data for odd. It is computed on the latched word, not on the shifting register.
- PARITY: on tick, tx<=1, go to STOP1.
- STOP1: on tick:
  - if stop2: go to STOP2 (tx stays 1);
  - else: end of frame (rule below).
- STOP2: on tick, end of frame.
- End of frame, on the terminating tick:
  - if hold_full, load the next word immediately (tx<=0, state START, hold_full cleared). This gives zero idle gap.
  - else go to IDLE with tx=1.
- Frame length: 10 to 12 bit periods (1 start + 8 data + 0/1 parity + 1/2 stop).
- Simultaneous accept and tick in the same cycle:
  - If hold was empty, the word is stored this cycle. The tick is not used to start it; the start bit begins at the next tick.
  - A tick that loads from hold while hold_full cannot coincide with an accept, because tx_ready was 0 in that cycle.
- tx_ready rises in the cycle after hold is consumed.
- Stalled baud_clk (generator disabled): state and tx freeze indefinitely; the handshake still accepts into hold if it is empty.
- Reset mid-frame: tx returns to 1 asynchronously, and the in-flight word and held word are discarded.
- Config inputs change only with the accepted word; mid-frame changes have no effect.
- tx_busy = (state != IDLE) | hold_full.

Decomposition:
- Package uart_pkg holds:
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP1, STOP2};
  - UART_DATA_W=8;
  - the baud_sel encoding constants shared with the generator (00=19200, 01=38400, 10=57600, 11=115200).
- One sub-module, baud_edge_det: registers baud_clk with reset-to-1 and emits baud_tick. The future uart_rx reuses it.

Test Plan:
1. Reset: hold rst_n=0 with baud_clk toggling -> tx=1, tx_ready=1, tx_busy=0. Release with baud_clk=1 -> no tick in the first cycle.
2. Plain frame: baud_clk period 16 clkin, tx_data=0xA5, parity_en=0, stop2=0 -> after the next rising edge, tx = 0,1,0,1,0,0,1,0,1,1, each held exactly 16 cycles; then IDLE, tx_busy=0.
3. Parity and stop bits: 0x03 with parity_en=1:
   - parity_odd=0 -> parity bit 0;
   - parity_odd=1 -> parity bit 1;
   - stop2=1 -> two 16-cycle stop bits, frame length 12 periods.
4. Back-to-back: tx_valid held with 0x55 then 0x0F -> tx_ready drops after the second accept. The 0x0F start bit immediately follows the 0x55 stop bit with no idle cycles.
5. Corner cases:
   - tx_valid asserted in the same cycle as baud_tick from IDLE -> the start bit begins at the following tick, not that one.
   - baud_clk held low mid-DATA for 100 cycles -> tx constant, state frozen, resumes correctly.
6. Reset mid-frame: assert rst_n=0 during data bit 3 with hold_full=1 -> tx=1 without a clkin edge. After release, tx_ready=1 and no residual frame is sent.
